// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared constants and types for the neuron stimulus path:
//                mode encoding, sequencer state encoding and the segment
//                table entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Width of the neuron current / membrane fixed-point words
    localparam int BITWIDTH  = 27;
    // Default width of a segment duration (in neuron done pulses)
    localparam int SEG_DUR_W = 16;

    // Neuron mode select values
    localparam logic MODE_HH   = 1'b1;
    localparam logic MODE_ADEX = 1'b0;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        NRST = 3'd2,
        RUN  = 3'd3,
        ADV  = 3'd4
    } seq_state_e;

    // One stimulus segment: mode, signed current, duration in samples
    typedef struct packed {
        logic                       mode;
        logic signed [BITWIDTH-1:0] cur;
        logic [SEG_DUR_W-1:0]       dur;
    } seg_t;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/stim_seg_table.sv
`default_nettype none
// ============================================================================
//  Module      : stim_seg_table
//  Description : Segment table for the stimulus sequencer. DEPTH entries of
//                {mode, current, duration}, one synchronous write port and
//                one combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_seg_table
    import neuron_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BITWIDTH = 27,
    parameter int DUR_W    = 16
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic                       wmode_i,
    input  logic signed [BITWIDTH-1:0] wcur_i,
    input  logic [DUR_W-1:0]           wdur_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic                       rmode_o,
    output logic signed [BITWIDTH-1:0] rcur_o,
    output logic [DUR_W-1:0]           rdur_o
);

    // Entry layout inside the storage word: {mode, cur, dur}
    localparam int EW = 1 + BITWIDTH + DUR_W;

    logic [EW-1:0] mem_q [DEPTH];

    // Synchronous write; the storage is deliberately left without reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wmode_i, wcur_i, wdur_i};
        end
    end

    // Combinational read of the addressed entry
    assign {rmode_o, rcur_o, rdur_o} = mem_q[raddr_i];

endmodule : stim_seg_table
`default_nettype wire

// File: rtl/neuron_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_stim_sequencer
//  Description : Plays a programmable table of {mode, i_ext, duration}
//                segments into the dual-mode neuron. Durations are counted
//                in neuron done strobes. The neuron is held in reset for
//                RST_CYC cycles at the first segment of a pass and at every
//                mode change.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_stim_sequencer
    import neuron_pkg::*;
#(
    parameter int BITWIDTH = 27,
    parameter int DEPTH    = 8,
    parameter int DUR_W    = 16,
    parameter int RST_CYC  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic                       cfg_mode,
    input  logic signed [BITWIDTH-1:0] cfg_cur,
    input  logic [DUR_W-1:0]           cfg_dur,
    input  logic [$clog2(DEPTH)-1:0]   n_seg,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       done,
    output logic                       mode,
    output logic signed [BITWIDTH-1:0] i_ext,
    output logic                       neuron_rstn,
    output logic [$clog2(DEPTH)-1:0]   seg_idx,
    output logic                       busy,
    output logic                       finished
);

    localparam int AW  = $clog2(DEPTH);
    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    seq_state_e                  state_q;
    logic                        mode_q;
    logic signed [BITWIDTH-1:0]  i_ext_q;
    logic                        nrstn_q;
    logic [AW-1:0]               seg_idx_q;
    logic                        busy_q;
    logic                        finished_q;
    logic [DUR_W-1:0]            dur_q;
    logic [DUR_W-1:0]            dur_cnt_q;
    logic [RCW-1:0]              rst_cnt_q;
    logic                        first_q;

    logic                        w_tbl_we;
    logic                        w_rd_mode;
    logic signed [BITWIDTH-1:0]  w_rd_cur;
    logic [DUR_W-1:0]            w_rd_dur;
    logic [DUR_W-1:0]            w_dur_last;

    // Table is only writable while the sequencer is idle
    assign w_tbl_we   = cfg_we & ~busy_q;
    assign w_dur_last = dur_q - DUR_W'(1);

    stim_seg_table #(
        .DEPTH    (DEPTH),
        .BITWIDTH (BITWIDTH),
        .DUR_W    (DUR_W)
    ) u_table (
        .clk      (clk),
        .we_i     (w_tbl_we),
        .waddr_i  (cfg_addr),
        .wmode_i  (cfg_mode),
        .wcur_i   (cfg_cur),
        .wdur_i   (cfg_dur),
        .raddr_i  (seg_idx_q),
        .rmode_o  (w_rd_mode),
        .rcur_o   (w_rd_cur),
        .rdur_o   (w_rd_dur)
    );

    // Sequencer FSM with sample and reset-hold counters; all outputs registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mode_q     <= MODE_HH;
            i_ext_q    <= '0;
            nrstn_q    <= 1'b0;
            seg_idx_q  <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            first_q    <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            if (abort) begin
                // Abort overrides everything, including a simultaneous start
                state_q <= IDLE;
                i_ext_q <= '0;
                nrstn_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        i_ext_q <= '0;
                        nrstn_q <= 1'b0;
                        if (start) begin
                            seg_idx_q <= '0;
                            first_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                    LOAD: begin
                        mode_q    <= w_rd_mode;
                        i_ext_q   <= w_rd_cur;
                        dur_q     <= w_rd_dur;
                        dur_cnt_q <= '0;
                        if (w_rd_dur == '0) begin
                            // Empty segment: skipped without touching the neuron reset
                            state_q <= ADV;
                        end else if (first_q || (w_rd_mode != mode_q)) begin
                            // First real segment of a pass (the neuron has been
                            // held in reset until now) or a mode switch
                            first_q   <= 1'b0;
                            nrstn_q   <= 1'b0;
                            rst_cnt_q <= '0;
                            state_q   <= NRST;
                        end else begin
                            // Same mode: membrane state carries over
                            nrstn_q <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                    NRST: begin
                        if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
                            nrstn_q <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + RCW'(1);
                        end
                    end
                    RUN: begin
                        nrstn_q <= 1'b1;
                        if (done) begin
                            if (dur_cnt_q == w_dur_last) begin
                                state_q <= ADV;
                            end else begin
                                dur_cnt_q <= dur_cnt_q + DUR_W'(1);
                            end
                        end
                    end
                    ADV: begin
                        if (seg_idx_q == n_seg) begin
                            if (loop) begin
                                // Wrap counts as a fresh pass: neuron is reset again
                                seg_idx_q <= '0;
                                first_q   <= 1'b1;
                                state_q   <= LOAD;
                            end else begin
                                finished_q <= 1'b1;
                                busy_q     <= 1'b0;
                                i_ext_q    <= '0;
                                nrstn_q    <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else begin
                            seg_idx_q <= seg_idx_q + AW'(1);
                            state_q   <= LOAD;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mode        = mode_q;
    assign i_ext       = i_ext_q;
    assign neuron_rstn = nrstn_q;
    assign seg_idx     = seg_idx_q;
    assign busy        = busy_q;
    assign finished    = finished_q;

endmodule : neuron_stim_sequencer
`default_nettype wire

// File: tb/tb_neuron_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_stim_sequencer
//  Description : Self-checking bench for neuron_stim_sequencer. A segment-
//                level reference model predicts every output each cycle;
//                directed scenarios pin the model with literal timings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_stim_sequencer;
    import neuron_pkg::*;

    localparam int BW    = 27;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int RSTC  = 4;
    localparam int AW    = 3;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic                 cfg_mode = 1'b0;
    logic signed [BW-1:0] cfg_cur = '0;
    logic [DW-1:0]        cfg_dur = '0;
    logic [AW-1:0]        n_seg = '0;
    logic                 loop = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 done = 1'b0;
    logic                 mode;
    logic signed [BW-1:0] i_ext;
    logic                 neuron_rstn;
    logic [AW-1:0]        seg_idx;
    logic                 busy;
    logic                 finished;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    neuron_stim_sequencer #(
        .BITWIDTH (BW),
        .DEPTH    (DEPTH),
        .DUR_W    (DW),
        .RST_CYC  (RSTC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_mode    (cfg_mode),
        .cfg_cur     (cfg_cur),
        .cfg_dur     (cfg_dur),
        .n_seg       (n_seg),
        .loop        (loop),
        .start       (start),
        .abort       (abort),
        .done        (done),
        .mode        (mode),
        .i_ext       (i_ext),
        .neuron_rstn (neuron_rstn),
        .seg_idx     (seg_idx),
        .busy        (busy),
        .finished    (finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: segment-level view. A pass walks entries 0..n_seg;
    // each entry costs one load cycle, an optional RST_CYC-cycle neuron
    // reset, its dur counted samples, and one advance cycle.
    // ------------------------------------------------------------------
    seg_t                 tbl [DEPTH];
    bit                   m_act, m_first, m_load, m_adv;
    int                   m_hold, m_left;
    logic [AW-1:0]        m_seg;
    logic                 m_mode, m_nrst, m_busy, m_fin;
    logic signed [BW-1:0] m_iext;

    always @(posedge clk or negedge rstn) begin
        seg_t e;
        bit   need;
        if (!rstn) begin
            m_act = 0; m_first = 0; m_load = 0; m_adv = 0;
            m_hold = 0; m_left = 0;
            m_seg = '0; m_mode = 1'b1; m_nrst = 1'b0;
            m_busy = 1'b0; m_fin = 1'b0; m_iext = '0;
        end else begin
            m_fin = 1'b0;
            if (!m_act && cfg_we) tbl[cfg_addr] = '{cfg_mode, cfg_cur, cfg_dur};
            if (abort) begin
                m_act = 0; m_busy = 0; m_iext = '0; m_nrst = 0;
                m_load = 0; m_adv = 0; m_hold = 0; m_left = 0;
            end else if (!m_act) begin
                m_iext = '0; m_nrst = 0;
                if (start) begin
                    m_act = 1; m_busy = 1; m_seg = '0; m_first = 1; m_load = 1;
                end
            end else if (m_load) begin
                e = tbl[m_seg];
                m_load = 0;
                need = m_first || (e.mode != m_mode);
                m_mode = e.mode;
                m_iext = e.cur;
                if (e.dur == 0) begin
                    m_adv = 1;
                end else begin
                    m_left = int'(e.dur);
                    if (need) begin
                        m_first = 0; m_nrst = 0; m_hold = RSTC;
                    end else begin
                        m_nrst = 1;
                    end
                end
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_nrst = 1;
            end else if (m_left > 0) begin
                if (done) begin
                    m_left--;
                    if (m_left == 0) m_adv = 1;
                end
            end else if (m_adv) begin
                m_adv = 0;
                if (m_seg == n_seg) begin
                    if (loop) begin
                        m_seg = '0; m_first = 1; m_load = 1;
                    end else begin
                        m_act = 0; m_busy = 0; m_fin = 1; m_iext = '0; m_nrst = 0;
                    end
                end else begin
                    m_seg = m_seg + AW'(1);
                    m_load = 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mode",        longint'(mode),        longint'(m_mode));
            chk("i_ext",       longint'(i_ext),       longint'(m_iext));
            chk("neuron_rstn", longint'(neuron_rstn), longint'(m_nrst));
            chk("seg_idx",     longint'(seg_idx),     longint'(m_seg));
            chk("busy",        longint'(busy),        longint'(m_busy));
            chk("finished",    longint'(finished),    longint'(m_fin));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called right after a falling edge)
    // ------------------------------------------------------------------
    logic signed [BW-1:0] watch_cur;
    bit                   saw_cur;

    task automatic write_entry(input int a, input logic md,
                               input logic signed [BW-1:0] cu, input logic [DW-1:0] du);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_mode = md; cfg_cur = cu; cfg_dur = du;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_seq(input int done_pct, input int budget,
                           output int cyc, output int nlow, output bit got_fin);
        start = 1'b1;
        done  = ($urandom_range(99) < done_pct);
        cyc = 0; nlow = 0; got_fin = 1'b0; saw_cur = 1'b0;
        while (!got_fin && cyc < budget) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy && !neuron_rstn) nlow++;
            if (busy && i_ext == watch_cur) saw_cur = 1'b1;
            if (finished) got_fin = 1'b1;
            done = ($urandom_range(99) < done_pct);
        end
        done = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, nlow, falls, wraps;
        bit got;
        logic [AW-1:0] pseg;
        logic pn;

        repeat (3) @(negedge clk);
        chk("rst_mode",  longint'(mode), 1);
        chk("rst_iext",  longint'(i_ext), 0);
        chk("rst_nrstn", longint'(neuron_rstn), 0);
        chk("rst_seg",   longint'(seg_idx), 0);
        chk("rst_busy",  longint'(busy), 0);
        chk("rst_fin",   longint'(finished), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Single segment {HH,1000,5}
        write_entry(0, MODE_HH, 27'sd1000, 16'd5);
        n_seg = '0; loop = 1'b0; watch_cur = 27'sd1000;
        run_seq(100, 40, cyc, nlow, got);
        chk("s1_finished", longint'(got), 1);
        chk("s1_cycles",   cyc, 12);
        chk("s1_low",      nlow, 5);
        chk("s1_cur",      longint'(saw_cur), 1);
        chk("s1_iext_end", longint'(i_ext), 0);

        // Two segments, same mode: no reset at the boundary
        write_entry(0, MODE_HH, 27'sd500, 16'd3);
        write_entry(1, MODE_HH, -27'sd200, 16'd2);
        n_seg = AW'(1); watch_cur = -27'sd200;
        run_seq(100, 40, cyc, nlow, got);
        chk("s2_cycles", cyc, 14);
        chk("s2_low",    nlow, 5);
        chk("s2_cur",    longint'(saw_cur), 1);

        // Mode switch: second reset, done ignored while held in reset
        write_entry(0, MODE_HH, 27'sd0, 16'd2);
        write_entry(1, MODE_ADEX, 27'sd300, 16'd2);
        watch_cur = 27'sd300;
        run_seq(100, 40, cyc, nlow, got);
        chk("s3_cycles", cyc, 17);
        chk("s3_low",    nlow, 9);
        chk("s3_cur",    longint'(saw_cur), 1);

        // Zero-duration entry is skipped
        write_entry(0, MODE_HH, 27'sd100, 16'd0);
        write_entry(1, MODE_HH, 27'sd200, 16'd1);
        watch_cur = 27'sd200;
        run_seq(100, 40, cyc, nlow, got);
        chk("s4_cycles", cyc, 10);
        chk("s4_low",    nlow, 7);
        chk("s4_cur",    longint'(saw_cur), 1);

        // Loop with wrap reset, then abort
        write_entry(0, MODE_HH, 27'sd10, 16'd2);
        write_entry(1, MODE_HH, 27'sd20, 16'd2);
        loop = 1'b1; start = 1'b1; done = 1'b1;
        @(negedge clk);
        start = 1'b0; pseg = seg_idx; pn = neuron_rstn; falls = 0; wraps = 0;
        for (int c = 2; c <= 25; c++) begin
            @(negedge clk);
            if (pn && !neuron_rstn) falls++;
            if (pseg == AW'(1) && seg_idx == '0) wraps++;
            pseg = seg_idx; pn = neuron_rstn;
        end
        chk("loop_wraps", wraps, 2);
        chk("loop_falls", falls, 1);
        abort = 1'b1; done = 1'b0;
        @(negedge clk);
        abort = 1'b0; loop = 1'b0;
        chk("abort_busy",  longint'(busy), 0);
        chk("abort_fin",   longint'(finished), 0);
        chk("abort_nrstn", longint'(neuron_rstn), 0);
        chk("abort_iext",  longint'(i_ext), 0);

        // start and abort together
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", longint'(busy), 0);
        @(negedge clk);
        chk("sa_busy2", longint'(busy), 0);

        // Asynchronous reset in RUN
        write_entry(0, MODE_ADEX, 27'sd1000, 16'd5);
        n_seg = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ar_busy_before", longint'(busy), 1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_mode",  longint'(mode), 1);
        chk("ar_iext",  longint'(i_ext), 0);
        chk("ar_nrstn", longint'(neuron_rstn), 0);
        chk("ar_busy",  longint'(busy), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Config write while busy must be ignored
        write_entry(0, MODE_HH, 27'sd1000, 16'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        write_entry(0, MODE_ADEX, 27'sd7, 16'd1);
        done = 1'b1;
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        watch_cur = 27'sd1000;
        run_seq(100, 40, cyc, nlow, got);
        chk("guard_cycles", cyc, 12);
        chk("guard_cur",    longint'(saw_cur), 1);

        // Randomised sequences checked cycle-by-cycle against the model
        for (int s = 0; s < 12; s++) begin
            for (int a = 0; a < DEPTH; a++)
                write_entry(a, 1'($urandom_range(1)), BW'($urandom), DW'($urandom_range(4)));
            loop = ($urandom_range(3) == 0);
            if (loop) write_entry(0, 1'($urandom_range(1)), BW'($urandom), DW'($urandom_range(4, 1)));
            n_seg = AW'($urandom_range(DEPTH - 1));
            start = 1'b1;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                start    = ($urandom_range(15) == 0);
                done     = ($urandom_range(1) == 1);
                abort    = (loop && c == 300) || ($urandom_range(299) == 0);
                cfg_we   = ($urandom_range(7) == 0);
                cfg_addr = AW'($urandom_range(DEPTH - 1));
                cfg_mode = 1'($urandom_range(1));
                cfg_cur  = BW'($urandom);
                cfg_dur  = DW'($urandom_range(3, 1));
            end
            @(negedge clk);
            start = 1'b0; done = 1'b0; cfg_we = 1'b0; abort = 1'b1;
            @(negedge clk);
            abort = 1'b0; loop = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_neuron_stim_sequencer
`default_nettype wire
